// File: rtl/countdown_timer_n_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the BCD countdown timer.
//   state_t      : four-state controller encoding (IDLE, RUN, PAUSE, DONE)
//   bcd_t        : one BCD digit (4 bits)
//   BCD_MAX      : largest legal BCD digit, also the wrap value of most digits
//   SEC_TENS_MAX : wrap value of the seconds-tens digit (59 -> 00 style borrow)
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // True when a keypad nibble is a legal decimal digit.
  function automatic logic is_bcd(input bcd_t value);
    return value <= BCD_MAX;
  endfunction

endpackage

// File: rtl/countdown_timer_n_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_n_if
// Keypad/control inputs and display/status outputs of the countdown timer.
//   data     : BCD keypad digit
//   loadn    : digit-entry strobe, active low
//   start    : start/resume request
//   stop     : pause/cancel request
//   sec_ones : seconds units        sec_tens : seconds tens
//   mins     : minute digits, minute units in the low nibble
//   zero     : all digits are 0     running  : counting down
//   done     : one-cycle expiry pulse   alarm : expired, waiting for the user
// master drives the controls (keypad side), slave is the timer itself.
// -----------------------------------------------------------------------------
interface countdown_timer_n_if #(
  parameter int MIN_DIGITS = 2
);
  import timer_pkg::*;

  bcd_t                    data;
  logic                    loadn;
  logic                    start;
  logic                    stop;
  bcd_t                    sec_ones;
  bcd_t                    sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic                    zero;
  logic                    running;
  logic                    done;
  logic                    alarm;

  modport master (
    output data, loadn, start, stop,
    input  sec_ones, sec_tens, mins, zero, running, done, alarm
  );

  modport slave (
    input  data, loadn, start, stop,
    output sec_ones, sec_tens, mins, zero, running, done, alarm
  );

endinterface

// File: rtl/countdown_timer_n_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One BCD digit of the countdown chain. Loads from its right-hand neighbour
// during keypad entry, or counts down by one when enabled.
//   clock    : rising-edge clock
//   clearn   : asynchronous active-low reset, digit -> 0
//   shift_en : load shift_in (takes priority over dec_en)
//   shift_in : value to load
//   dec_en   : decrement by one this edge
//   digit    : current value
//   borrow   : digit is 0, so a decrement here must propagate to the next digit
// WRAP_VAL is the value a 0 turns into when it is decremented.
// -----------------------------------------------------------------------------
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t WRAP_VAL = BCD_MAX
) (
  input  logic clock,
  input  logic clearn,
  input  logic shift_en,
  input  bcd_t shift_in,
  input  logic dec_en,
  output bcd_t digit,
  output logic borrow
);

  bcd_t r_digit;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_digit <= '0;
    end else if (shift_en) begin
      r_digit <= shift_in;
    end else if (dec_en) begin
      // Values above WRAP_VAL (e.g. 90 s entered into sec_tens) simply count
      // down normally; only 0 wraps.
      r_digit <= (r_digit == '0) ? WRAP_VAL : r_digit - 4'd1;
    end
  end

  assign digit  = r_digit;
  assign borrow = (r_digit == '0);

endmodule

// File: rtl/countdown_timer_n.sv
// -----------------------------------------------------------------------------
// countdown_timer_n
// Kitchen-style BCD countdown timer with keypad entry, start/pause/cancel and
// a one-second prescaler.
//   clock  : rising-edge clock
//   clearn : asynchronous active-low reset
//   bus    : keypad/control inputs and display/status outputs (slave side)
// Parameters: MIN_DIGITS (1..4) minute digits, TICK_DIV (1..2^24) clocks per
// second. Digit chain index 0 is sec_ones, 1 is sec_tens, 2.. are minutes.
// -----------------------------------------------------------------------------
module countdown_timer_n
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                 clock,
  input  logic                 clearn,
  countdown_timer_n_if.slave   bus
);

  localparam int NDIG = MIN_DIGITS + 2;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_done;
  logic          w_done_next;

  bcd_t            w_digit    [NDIG];
  bcd_t            w_shift_in [NDIG];
  logic [NDIG-1:0] w_borrow;
  logic [NDIG-1:0] w_dec_en;

  logic w_shift_en;
  logic w_clear;
  logic w_dec;
  logic w_tick;
  logic w_zero;
  logic w_last;

  // Every borrow flag is "digit == 0", so all of them set means all-zero.
  assign w_zero = &w_borrow;
  // 0...01: the next decrement lands on all-zero.
  assign w_last = (w_digit[0] == 4'd1) && (&w_borrow[NDIG-1:1]);
  assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

  // ---------------------------------------------------------------------------
  // Digit chain. Cancelling reuses the shift path with zeros fed into every
  // digit, so the digits need no separate clear input.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign w_shift_in[gi] = w_clear ? bcd_t'(0) : bus.data;
        assign w_dec_en[gi]   = w_dec;
      end else begin : g_rest
        assign w_shift_in[gi] = w_clear ? bcd_t'(0) : w_digit[gi-1];
        assign w_dec_en[gi]   = w_dec_en[gi-1] & w_borrow[gi-1];
      end

      if (gi == 1) begin : g_sec_tens
        bcd_down_digit #(.WRAP_VAL(SEC_TENS_MAX)) u_digit (
          .clock    (clock),
          .clearn   (clearn),
          .shift_en (w_shift_en),
          .shift_in (w_shift_in[gi]),
          .dec_en   (w_dec_en[gi]),
          .digit    (w_digit[gi]),
          .borrow   (w_borrow[gi])
        );
      end else begin : g_decade
        bcd_down_digit #(.WRAP_VAL(BCD_MAX)) u_digit (
          .clock    (clock),
          .clearn   (clearn),
          .shift_en (w_shift_en),
          .shift_in (w_shift_in[gi]),
          .dec_en   (w_dec_en[gi]),
          .digit    (w_digit[gi]),
          .borrow   (w_borrow[gi])
        );
      end
    end

    for (gi = 0; gi < MIN_DIGITS; gi++) begin : g_mins
      assign bus.mins[4*gi +: 4] = w_digit[gi+2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Controller: stop beats start beats loadn.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_done_next  = 1'b0;
    w_shift_en   = 1'b0;
    w_clear      = 1'b0;
    w_dec        = 1'b0;

    if (bus.stop) begin
      // Pausing freezes digits and prescaler; anywhere else stop cancels.
      if (r_state == RUN) begin
        w_state_next = PAUSE;
      end else begin
        w_state_next = IDLE;
        w_shift_en   = 1'b1;
        w_clear      = 1'b1;
      end
    end else if (bus.start && (r_state == IDLE || r_state == PAUSE) && !w_zero) begin
      w_state_next = RUN;
      w_presc_next = '0;
    end else if (r_state == RUN) begin
      // start while running lands here too and is a no-op.
      w_presc_next = w_tick ? '0 : r_presc + PW'(1);
      if (w_tick && !w_zero) begin
        w_dec = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
          w_done_next  = 1'b1;
        end
      end
    end else if (!bus.loadn && is_bcd(bus.data)) begin
      // A rejected start (count at zero) falls through so entry still works.
      w_shift_en = 1'b1;
      if (r_state == DONE) begin
        w_state_next = IDLE;
      end
    end
  end

  assign bus.sec_ones = w_digit[0];
  assign bus.sec_tens = w_digit[1];
  assign bus.zero     = w_zero;
  assign bus.running  = (r_state == RUN);
  assign bus.alarm    = (r_state == DONE);
  assign bus.done     = r_done;

endmodule

// File: doc/countdown_timer_n.md
COUNTDOWN_TIMER_N -- requirements
Module: countdown_timer_n

Interface
REQ-001 Parameter MIN_DIGITS, default 2, number of BCD minute digits; legal range 1..4.
REQ-002 Parameter TICK_DIV, default 1, clock cycles per one-second decrement; legal range 1..2^24.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 clearn  input  1  reset, asynchronous and active-low.
REQ-005 data  input  4  BCD keypad digit for entry.
REQ-006 loadn  input  1  synchronous digit-entry strobe, active low.
REQ-007 start  input  1  synchronous start/resume request, active high.
REQ-008 stop  input  1  synchronous pause/cancel request, active high.
REQ-009 sec_ones  output  4  BCD seconds units.
REQ-010 sec_tens  output  4  BCD seconds tens.
REQ-011 mins  output  4*MIN_DIGITS  BCD minute digits; the least significant nibble holds minute units.
REQ-012 zero  output  1  high when every digit equals 0; combinational from the digit registers.
REQ-013 running  output  1  high in state RUN.
REQ-014 done  output  1  one-cycle pulse on expiry.
REQ-015 alarm  output  1  high in state DONE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and DONE.
REQ-017 Same-cycle input priority SHALL be stop > start > loadn.
REQ-018 Digit entry: when loadn=0 and state is not RUN, a data value of 9 or less SHALL shift the digit chain one place left: data->sec_ones, sec_ones->sec_tens, sec_tens->mins[3:0], and so on up the minute digits; the top minute digit is discarded.
REQ-019 A data value greater than 9 SHALL be ignored, with no shift.
REQ-020 loadn SHALL be ignored while in RUN.
REQ-021 loadn in DONE SHALL perform the shift and move the FSM to IDLE.
REQ-022 sec_tens SHALL accept any value 0..9 on entry, so 90 seconds is a legal entry.
REQ-023 start in IDLE or PAUSE with zero=0 SHALL move the FSM to RUN and clear the prescaler.
REQ-024 start with zero=1 SHALL be ignored.
REQ-025 stop in RUN SHALL move the FSM to PAUSE and hold the digits.
REQ-026 stop in IDLE, PAUSE or DONE SHALL clear all digits to 0 and move the FSM to IDLE.
REQ-027 Prescaler: in RUN it SHALL count 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1); the prescaler SHALL hold its value outside RUN.
REQ-028 The first decrement SHALL occur exactly TICK_DIV cycles after the edge that accepted start.
REQ-029 On a tick, the count SHALL decrement by one second with a borrow chain: sec_ones 0->9 borrows; sec_tens 0->5 borrows; each minute digit 0->9 borrows into the next.
REQ-030 A sec_tens value above 5 SHALL decrement normally (9->8, etc.).
REQ-031 The tick on which the count reaches all-zero SHALL also move the FSM to DONE at the same edge.
REQ-032 done SHALL be high for exactly the one cycle following that edge.
REQ-033 The digits SHALL never decrement below zero, and no wrap-around SHALL occur.
REQ-034 A stop arriving on a tick cycle SHALL win: there is no decrement, and the FSM moves to PAUSE.
REQ-035 start in RUN SHALL have no effect.
REQ-036 start in DONE SHALL be ignored because zero=1.

Reset
REQ-037 clearn=0 SHALL asynchronously force state IDLE, all digits 0 and prescaler 0.
REQ-038 While clearn=0, outputs SHALL be: done=0, running=0, alarm=0, zero=1.
REQ-039 Reset asserted mid-RUN SHALL abort the countdown; no done pulse SHALL be produced.
REQ-040 After clearn deasserts, the first active edge SHALL act on inputs normally.

Structure
REQ-041 Package timer_pkg SHALL hold the state enumeration, the BCD digit type (4 bits) and constants BCD_MAX=9 and SEC_TENS_MAX=5.
REQ-042 Sub-module bcd_down_digit SHALL be instantiated once per digit (MIN_DIGITS+2 instances).
REQ-043 bcd_down_digit ports: clock, clearn, shift_en, shift_in, dec_en, wrap value parameter; outputs digit and borrow.
REQ-044 The FSM and prescaler SHALL reside in countdown_timer_n.

Verification
REQ-045 Reset, then keys 1,3,0 with MIN_DIGITS=2 -> mins=8'h01, sec_tens=3, sec_ones=0.
REQ-046 Start with TICK_DIV=4 -> first decrement to 1:29 on the 4th edge after start.
REQ-047 Entry 1:00, start, TICK_DIV=1 -> 0:59 after one tick.
REQ-048 Entry 1:00 continued -> 0:00 after 60 ticks, with done high for exactly 1 cycle and alarm held high.
REQ-049 Entry 0:90 (keys 9,0), start, TICK_DIV=1 -> sequence 0:90, 0:89 … 0:00; DONE after 90 ticks.
REQ-050 RUN at 0:05 with stop and tick in the same cycle -> PAUSE, count still 0:05.
REQ-051 From that PAUSE, loadn=0 with data=4 -> 0:54; a second stop -> 0:00 and IDLE.
REQ-052 clearn pulsed low mid-RUN between clock edges -> digits 0 and IDLE immediately, no done pulse.
REQ-053 data=4'hA with loadn=0 -> no shift.
